top_level_dec: RTL and testbench

RSA decryption top level: computes message = cipher^d mod n by right-to-left binary exponentiation over a WIDTH-bit private exponent. It is the receive-side counterpart of the encryption top level. It uses one internal sequential interleaved modular multiplier (one bit per cycle), so no double-width product or separate divider is needed. Operands are latched on a start handshake, and the result is held with a level done until the next start.

---
 rtl/top_level_dec.sv | 207 ++++++++++++++++++++
 tb/tb_top_level_dec.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/top_level_dec.sv
// top_level_dec: RSA decryption, message = cipher^d mod n, using right-to-left
// binary exponentiation and one shared bit-serial interleaved modular multiplier
// (one multiplier bit per cycle, WIDTH+1 cycles per modmul).
// Optional build macro: DEC_EARLY_EXIT_EN stops the exponent scan once the
// remaining exponent bits are all zero. The result is unchanged; only latency
// shrinks.
// Handshake: start is a single-cycle request sampled only in IDLE. busy is high
// from the cycle after acceptance until done rises. done is a level that holds
// message and err until the next accepted start.
module top_level_dec #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] cipher_in,
  input  logic [WIDTH-1:0] d_key,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] message,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic [2:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef DEC_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_STEP = 3'd2,
    S_MULT = 3'd3,
    S_SQR  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_result;
  logic             r_nbad;
  logic [CW-1:0]    r_exp_cnt;
  // Modular-multiplier datapath: the first cycle in PREP/MULT/SQR is the load cycle.
  logic             r_mm_load;
  logic [CW-1:0]    r_mm_cnt;
  logic [WIDTH-1:0] r_mm_a;
  logic [WIDTH-1:0] r_mm_b;
  logic [WIDTH-1:0] r_mm_r;

  logic [WIDTH:0]   w_n_ext;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_red1;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mm_next;
  logic             w_mm_last;
  logic             w_exp_last;
  logic [WIDTH-1:0] w_d_shift;
  logic             w_sqr_fin;
  logic             w_prep_fin;
  logic [WIDTH-1:0] w_ld_a;
  logic [WIDTH-1:0] w_ld_b;

  // One interleaved step: r = 2r mod n, then add a when the current b bit is set.
  // r < n holds on entry, so every intermediate fits in WIDTH+1 bits.
  always_comb begin
    w_n_ext   = {1'b0, r_n};
    w_dbl     = {r_mm_r, 1'b0};
    w_red1    = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
    w_sum     = w_red1 + (r_mm_b[WIDTH-1] ? {1'b0, r_mm_a} : '0);
    w_mm_next = (w_sum >= w_n_ext) ? (w_sum[WIDTH-1:0] - r_n) : w_sum[WIDTH-1:0];
  end

  // Loop-control terms for the exponent scan and the multiplier iterations.
  always_comb begin
    w_mm_last  = (r_mm_cnt == CW'(WIDTH - 1));
    w_exp_last = (r_exp_cnt == CW'(WIDTH - 1));
    w_d_shift  = r_d >> 1;
    w_sqr_fin  = w_exp_last || (EARLY_EXIT && (w_d_shift == '0));
    w_prep_fin = EARLY_EXIT && (r_d == '0);
  end

  // Multiplier operand selection for the load cycle of each modmul phase.
  always_comb begin
    w_ld_a = r_base;
    w_ld_b = r_base;
    case (r_state)
      S_PREP: begin
        w_ld_a = WIDTH'(1);
        w_ld_b = r_c;
      end
      S_MULT: begin
        w_ld_a = r_result;
        w_ld_b = r_base;
      end
      default: begin
        w_ld_a = r_base;
        w_ld_b = r_base;
      end
    endcase
  end

  // Control FSM with registered outputs and the multiplier datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      message   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      r_c       <= '0;
      r_d       <= '0;
      r_n       <= '0;
      r_base    <= '0;
      r_result  <= '0;
      r_nbad    <= 1'b0;
      r_exp_cnt <= '0;
      r_mm_load <= 1'b0;
      r_mm_cnt  <= '0;
      r_mm_a    <= '0;
      r_mm_b    <= '0;
      r_mm_r    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_c       <= cipher_in;
            r_d       <= d_key;
            r_n       <= n;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b1;
            r_exp_cnt <= '0;
            r_mm_load <= 1'b1;
            // A modulus below 2 has no valid residue system: report at FIN.
            if (n < WIDTH'(2)) begin
              r_nbad   <= 1'b1;
              r_result <= '0;
              r_state  <= S_FIN;
            end else begin
              r_nbad   <= 1'b0;
              r_result <= WIDTH'(1);
              r_state  <= S_PREP;
            end
          end
        end

        S_STEP: begin
          r_state <= r_d[0] ? S_MULT : S_SQR;
        end

        S_PREP, S_MULT, S_SQR: begin
          if (r_mm_load) begin
            r_mm_r    <= '0;
            r_mm_a    <= w_ld_a;
            r_mm_b    <= w_ld_b;
            r_mm_cnt  <= '0;
            r_mm_load <= 1'b0;
          end else begin
            r_mm_r   <= w_mm_next;
            r_mm_b   <= {r_mm_b[WIDTH-2:0], 1'b0};
            r_mm_cnt <= r_mm_cnt + CW'(1);
            if (w_mm_last) begin
              r_mm_load <= 1'b1;
              case (r_state)
                S_PREP: begin
                  r_base  <= w_mm_next;
                  r_state <= w_prep_fin ? S_FIN : S_STEP;
                end
                S_MULT: begin
                  r_result <= w_mm_next;
                  r_state  <= S_SQR;
                end
                default: begin
                  r_base    <= w_mm_next;
                  r_d       <= w_d_shift;
                  r_exp_cnt <= r_exp_cnt + CW'(1);
                  r_state   <= w_sqr_fin ? S_FIN : S_STEP;
                end
              endcase
            end
          end
        end

        S_FIN: begin
          message <= r_result;
          err     <= r_nbad;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_top_level_dec.sv
// Bench for top_level_dec: an 8-bit instance for directed and random runs,
// and a 128-bit instance for the RSA round-trip vector. The expected message,
// error flag and latency come from a modular-exponentiation reference model
// and the closed-form latency rule.
module tb_top_level_dec;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // 8-bit instance
  logic         s8_start;
  logic [7:0]   c8, d8, n8, m8;
  logic         done8, busy8, err8;
  logic [2:0]   st8;

  // 128-bit instance
  logic         s128_start;
  logic [127:0] c128, d128, n128, m128;
  logic         done128, busy128, err128;
  logic [2:0]   st128;

  top_level_dec #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8_start),
    .cipher_in(c8), .d_key(d8), .n(n8),
    .message(m8), .done(done8), .busy(busy8), .err(err8),
    .o_dbg_state(st8)
  );

  top_level_dec #(.WIDTH(128)) dut128 (
    .clk(clk), .reset(reset), .start(s128_start),
    .cipher_in(c128), .d_key(d128), .n(n128),
    .message(m128), .done(done128), .busy(busy128), .err(err128),
    .o_dbg_state(st128)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input string what,
                       input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.%s: got %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint unsigned ref_modexp(input longint unsigned c,
      input longint unsigned d, input longint unsigned nn, input int w);
    longint unsigned r, b;
    r = 1;
    b = c % nn;
    for (int i = 0; i < w; i++) begin
      if (i < 64 && ((d >> i) & 64'd1) == 64'd1) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r;
  endfunction

  function automatic int ref_latency(input longint unsigned d, input int w);
    int top, sum, bit_i;
`ifdef DEC_EARLY_EXIT_EN
    top = 0;
    for (int i = 0; i < 64; i++) if (((d >> i) & 64'd1) == 64'd1) top = i + 1;
`else
    top = w;
`endif
    sum = 0;
    for (int i = 0; i < top; i++) begin
      bit_i = (i < 64) ? int'((d >> i) & 64'd1) : 0;
      sum += 1 + (w + 1) * (1 + bit_i);
    end
    return 1 + (w + 1) + sum + 1;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge. Optionally injects start pulses while the run is busy;
  // those must be ignored.
  task automatic run8(input logic [7:0] c, input logic [7:0] d,
                      input logic [7:0] nn, input bit inject, input string tag);
    longint unsigned exp_msg;
    int  exp_lat, k;
    bit  exp_err, busy_ok;
    exp_err = (nn < 8'd2);
    exp_msg = exp_err ? 64'd0 : ref_modexp(c, d, nn, 8);
    exp_lat = exp_err ? 2 : ref_latency(d, 8);
    exp_q.push_back(128'(exp_msg));
    c8 = c; d8 = d; n8 = nn; s8_start = 1'b1;
    @(negedge clk);
    s8_start = 1'b0;
    c8 = 8'($urandom); d8 = 8'($urandom); n8 = 8'($urandom);
    check(tag, "done_clr", done8, 0);
    check(tag, "err_clr", err8, 0);
    k = 1;
    busy_ok = 1'b1;
    while (!done8 && k < 4000) begin
      if (!busy8) busy_ok = 1'b0;
      s8_start = inject && ($urandom_range(0, 3) == 0);
      if (s8_start) begin
        c8 = 8'($urandom); d8 = 8'($urandom); n8 = 8'($urandom);
      end
      @(negedge clk);
      k++;
    end
    s8_start = 1'b0;
    check(tag, "latency", k, exp_lat);
    check(tag, "message", m8, exp_q.pop_front());
    check(tag, "err", err8, exp_err);
    check(tag, "busy_low", busy8, 0);
    check(tag, "busy_held", busy_ok, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int exp_lat128;
    bit busy_ok;
    logic [7:0] rc, rd, rn;

    reset = 1'b1;
    s8_start = 1'b0; c8 = '0; d8 = '0; n8 = '0;
    s128_start = 1'b0; c128 = '0; d128 = '0; n128 = '0;
    repeat (3) @(negedge clk);
    check("reset8", "message", m8, 0);
    check("reset8", "done", done8, 0);
    check("reset8", "busy", busy8, 0);
    check("reset8", "err", err8, 0);
    check("reset128", "message", m128, 0);
    check("reset128", "done", done128, 0);
    check("reset128", "busy", busy128, 0);
    check("reset128", "err", err128, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed: the worked example, exponent edges, c >= n, bad moduli.
    run8(8'd31, 8'd7, 8'd33, 1'b0, "plan_d7");
    run8(8'd5, 8'd0, 8'd33, 1'b0, "d_zero");
    run8(8'd37, 8'd1, 8'd33, 1'b0, "c_ge_n");
    run8(8'd9, 8'hAB, 8'd1, 1'b0, "n_one");
    run8(8'd31, 8'd7, 8'd33, 1'b0, "after_err");
    run8(8'd12, 8'hC5, 8'd0, 1'b0, "n_zero");
    run8(8'd31, 8'd7, 8'd33, 1'b1, "ignore_start");
    run8(8'd254, 8'd255, 8'd255, 1'b0, "all_ones");
    run8(8'd255, 8'd128, 8'd2, 1'b0, "n_two");
    run8(8'd0, 8'd5, 8'd97, 1'b0, "c_zero");

    // Randomized runs, back to back, some with ignored start pulses.
    for (int i = 0; i < 20; i++) begin
      rc = 8'($urandom);
      rd = 8'($urandom);
      rn = 8'($urandom_range(2, 255));
      run8(rc, rd, rn, 1'($urandom_range(0, 1)), "random");
    end

    // Reset in the middle of the first SQR phase (PREP 1..9, STEP 10, MULT 11..19).
    run8(8'd31, 8'd7, 8'd33, 1'b0, "pre_abort");
    c8 = 8'd31; d8 = 8'd7; n8 = 8'd33; s8_start = 1'b1;
    @(negedge clk);
    s8_start = 1'b0;
    repeat (21) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort", "done", done8, 0);
    check("abort", "busy", busy8, 0);
    check("abort", "message", m8, 0);
    check("abort", "err", err8, 0);
    reset = 1'b0;
    @(negedge clk);
    run8(8'd37, 8'd1, 8'd33, 1'b0, "post_abort");

    // 128-bit RSA round trip: 65^17 mod 3233 = 2790, decrypt with d = 2753.
    exp_lat128 = ref_latency(64'd2753, 128);
    exp_q.push_back(128'(ref_modexp(64'd2790, 64'd2753, 64'd3233, 128)));
    c128 = 128'd2790; d128 = 128'd2753; n128 = 128'd3233; s128_start = 1'b1;
    @(negedge clk);
    s128_start = 1'b0;
    c128 = {$urandom, $urandom, $urandom, $urandom};
    k = 1;
    busy_ok = 1'b1;
    while (!done128 && k < 40000) begin
      if (!busy128) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    check("rsa128", "latency", k, exp_lat128);
    check("rsa128", "message_model", m128, exp_q.pop_front());
    check("rsa128", "message_65", m128, 128'd65);
    check("rsa128", "err", err128, 0);
    check("rsa128", "busy_held", busy_ok, 1);
    check("final", "queue_empty", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
